// File: rtl/game_net_pkg.sv
// Shared definitions for the kart state link: packet geometry, field
// widths, the packed kart state and the packet checksum.
`timescale 1ns/1ps
package game_net_pkg;

    localparam int PKT_BYTES  = 8;
    localparam int PKT_DIBITS = 32;

    localparam int X_W    = 11;
    localparam int Y_W    = 11;
    localparam int DIR_W  = 9;
    localparam int GAME_W = 3;

    // Snapshot of one player's state, in wire order (x is sent first).
    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [DIR_W-1:0]  dir;
        logic [GAME_W-1:0] game;
        logic              rst;
    } kart_state_t;

    // XOR of the seven bytes preceding the checksum (byte0 in the top bits).
    function automatic logic [7:0] pkt_checksum(input logic [(PKT_BYTES-1)*8-1:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < PKT_BYTES - 1; i++) begin
            acc = acc ^ body[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/dibit_shifter.sv
// Packet serialiser: loads a whole packet and shifts it out two bits at a
// time, MSB dibit first, under a valid/ready handshake.
`timescale 1ns/1ps
module dibit_shifter
    import game_net_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [PKT_BYTES*8-1:0] load_data,
    input  logic                   ready,
    output logic                   valid,
    output logic [1:0]             dibit,
    output logic                   fire,
    output logic                   last
);

    // Handshake: a dibit is transferred on every cycle where valid && ready.
    // While ready is low, valid and dibit hold their values unchanged; dibit
    // is forced to zero whenever valid is low.

    logic [PKT_BYTES*8-1:0] shreg_q;
    logic [4:0]             idx_q;
    logic                   valid_q;

    // Load a packet, then advance one dibit per accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg_q <= load_data;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            shreg_q <= {shreg_q[PKT_BYTES*8-3:0], 2'b00};
            idx_q   <= idx_q + 5'd1;
            if (idx_q == 5'(PKT_DIBITS - 1)) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid = valid_q;
    assign dibit = valid_q ? shreg_q[PKT_BYTES*8-1 -: 2] : 2'b00;
    assign fire  = valid_q && ready;
    assign last  = valid_q && (idx_q == 5'(PKT_DIBITS - 1));

endmodule

// File: rtl/opp_state_tx.sv
// Transmit end of the kart state link. Once per frame trigger, snapshots
// the local player's state, builds an 8-byte packet (header, sequence,
// packed state, checksum) and streams it as dibits, followed by an
// inter-packet gap. Triggers arriving while busy collapse into one pending
// request whose inputs are captured when it actually starts.
`timescale 1ns/1ps
module opp_state_tx
    import game_net_pkg::*;
#(
    parameter logic [7:0] PKT_HEADER = 8'hA5,
    parameter int         GAP_CYCLES = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_trigger,
    input  logic [X_W-1:0]    player_x,
    input  logic [Y_W-1:0]    player_y,
    input  logic [DIR_W-1:0]  player_direction,
    input  logic [GAME_W-1:0] game_stat,
    input  logic              player_rst,
    input  logic              axior,
    output logic              axiov,
    output logic [1:0]        axiod,
    output logic              busy,
    output logic [7:0]        pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    // Current FSM state, kept as a named signal so it can be observed.
    tx_state_t state_q;
    tx_state_t state_d;

    logic [7:0] seq_q;
    logic [7:0] pkt_count_q;
    logic [7:0] gap_cnt_q;
    logic       pending_q;

    logic load;
    logic sh_fire;
    logic sh_last;
    logic pkt_done;
    logic gap_end;

    kart_state_t                  snap;
    logic [(PKT_BYTES-1)*8-1:0]   body;
    logic [PKT_BYTES*8-1:0]       pkt_word;

    assign snap     = {player_x, player_y, player_direction, game_stat, player_rst};
    assign body     = {PKT_HEADER, seq_q, snap, 5'b00000};
    assign pkt_word = {body, pkt_checksum(body)};

    assign pkt_done = sh_fire && sh_last;
    assign gap_end  = (state_q == ST_GAP) && (gap_cnt_q == 8'(GAP_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and shifter load decision.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send_trigger || pending_q) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                end
            end
            ST_SEND: begin
                if (pkt_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gap timer, sequence number, sent-packet counter and pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q   <= '0;
            seq_q       <= '0;
            pkt_count_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q + 8'd1;
            end else begin
                gap_cnt_q <= '0;
            end

            if (pkt_done) begin
                seq_q       <= seq_q + 8'd1;
                pkt_count_q <= pkt_count_q + 8'd1;
            end

            // A start consumes the request; any trigger while not starting
            // is remembered (further ones merge into the same request).
            if (load) begin
                pending_q <= 1'b0;
            end else if (send_trigger) begin
                pending_q <= 1'b1;
            end
        end
    end

    dibit_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (pkt_word),
        .ready     (axior),
        .valid     (axiov),
        .dibit     (axiod),
        .fire      (sh_fire),
        .last      (sh_last)
    );

    assign busy      = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_opp_state_tx.sv
// Bench for opp_state_tx: directed scenarios plus randomized packets,
// with a packet scoreboard fed by the stimulus and drained by a monitor.
`timescale 1ns/1ps
module tb_opp_state_tx;

    localparam int GAP = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        send_trigger = 1'b0;
    logic [10:0] player_x = '0;
    logic [10:0] player_y = '0;
    logic [8:0]  player_direction = '0;
    logic [2:0]  game_stat = '0;
    logic        player_rst = 1'b0;
    logic        axior = 1'b1;
    logic        axiov;
    logic [1:0]  axiod;
    logic        busy;
    logic [7:0]  pkt_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [7:0]  model_seq = 8'd0;

    // monitor state
    int          dib_cnt = 0;
    int          hi_cnt = 0;
    int          low_cnt = 0;
    int          done_cnt = 0;
    int          last_len = 0;
    bit          gap_armed = 0;
    bit          stalled_prev = 0;
    logic [1:0]  prev_d = 2'b00;
    logic [63:0] cur = '0;
    bit          rand_bp = 0;

    opp_state_tx dut (
        .clk              (clk),
        .rst              (rst),
        .send_trigger     (send_trigger),
        .player_x         (player_x),
        .player_y         (player_y),
        .player_direction (player_direction),
        .game_stat        (game_stat),
        .player_rst       (player_rst),
        .axior            (axior),
        .axiov            (axiov),
        .axiod            (axiod),
        .busy             (busy),
        .pkt_count        (pkt_count)
    );

    // clock
    always #5 clk = ~clk;

    // Reference packet built directly from the byte layout.
    function automatic logic [63:0] model_pkt(input logic [7:0] s, input logic [10:0] x,
                                              input logic [10:0] y, input logic [8:0] d,
                                              input logic [2:0] g, input logic r);
        logic [7:0]  b[8];
        logic [39:0] pl;
        logic [63:0] p;
        pl   = {x, y, d, g, r, 5'b00000};
        b[0] = 8'hA5;
        b[1] = s;
        for (int i = 0; i < 5; i++) b[2+i] = pl[39-8*i -: 8];
        b[7] = 8'h00;
        for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
        p = '0;
        for (int i = 0; i < 8; i++) p = {p[55:0], b[i]};
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_pkt();
        exp_q.push_back(model_pkt(model_seq, player_x, player_y, player_direction,
                                  game_stat, player_rst));
        model_seq = model_seq + 8'd1;
    endtask

    task automatic randomize_inputs();
        player_x         = 11'($urandom_range(0, 2047));
        player_y         = 11'($urandom_range(0, 2047));
        player_direction = 9'($urandom_range(0, 359));
        game_stat        = 3'($urandom_range(0, 7));
        player_rst       = 1'($urandom_range(0, 1));
    endtask

    // All driving happens at posedge+1.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic trigger();
        send_trigger = 1'b1;
        step(1);
        send_trigger = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        check("reset_axiov", 64'(axiov), 64'd0);
        check("reset_axiod", 64'(axiod), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_pkt_count", 64'(pkt_count), 64'd0);
        exp_q.delete();
        model_seq = 8'd0;
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input int target);
        int budget = 3000;
        while (done_cnt < target && budget > 0) begin
            if (rand_bp) axior = ($urandom_range(0, 3) != 0);
            step(1);
            budget--;
        end
        axior = 1'b1;
        n_tests++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL wait_done: got %0d packets expected %0d", done_cnt, target);
        end
    endtask

    task automatic wait_dib(input int n);
        int budget = 200;
        while (dib_cnt < n && budget > 0) begin
            step(1);
            budget--;
        end
        n_tests++;
        if (dib_cnt < n) begin
            n_fail++;
            $display("FAIL wait_dib: got %0d dibits expected %0d", dib_cnt, n);
        end
    endtask

    task automatic wait_idle();
        int budget = 200;
        while (busy && budget > 0) begin
            step(1);
            budget--;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy still %0d expected 0", busy);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            dib_cnt      = 0;
            hi_cnt       = 0;
            low_cnt      = 0;
            gap_armed    = 0;
            stalled_prev = 0;
        end else begin
            if (!axiov) begin
                n_tests++;
                if (axiod !== 2'b00) begin
                    n_fail++;
                    $display("FAIL axiod_idle: got %0h expected 0", axiod);
                end
                low_cnt++;
            end else begin
                if (hi_cnt == 0 && gap_armed) begin
                    n_tests++;
                    if (low_cnt < GAP) begin
                        n_fail++;
                        $display("FAIL gap_len: got %0d idle cycles expected >= %0d", low_cnt, GAP);
                    end
                end
                if (stalled_prev) begin
                    n_tests++;
                    if (axiod !== prev_d) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %0h expected %0h", axiod, prev_d);
                    end
                end
                hi_cnt++;
                if (axior) begin
                    cur = {cur[61:0], axiod};
                    dib_cnt++;
                    if (dib_cnt == 32) begin
                        n_tests++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL pkt_unexpected: got %0h expected none", cur);
                        end else begin
                            logic [63:0] e;
                            e = exp_q.pop_front();
                            if (cur !== e) begin
                                n_fail++;
                                $display("FAIL pkt_data: got %0h expected %0h", cur, e);
                            end
                        end
                        done_cnt++;
                        last_len  = hi_cnt;
                        dib_cnt   = 0;
                        hi_cnt    = 0;
                        low_cnt   = 0;
                        gap_armed = 1;
                    end
                end
            end
            stalled_prev = axiov && !axior;
            prev_d       = axiod;
        end
    end

    initial begin
        int base;
        logic [10:0] old_x;

        step(1);
        do_reset();

        // Snapshot and checksum against the known byte sequence.
        player_x = 11'd128; player_y = 11'd100; player_direction = 9'd0;
        game_stat = 3'd0; player_rst = 1'b0;
        exp_q.push_back(64'hA500_1001_9000_0024);
        model_seq = 8'd1;
        check("pre_trigger_axiov", 64'(axiov), 64'd0);
        base = done_cnt;
        trigger();
        check("latency_axiov", 64'(axiov), 64'd1);
        wait_done(base + 1);
        check("len_plain", 64'(last_len), 64'd32);
        check("count_after_1", 64'(pkt_count), 64'd1);
        check("busy_in_gap", 64'(busy), 64'd1);
        wait_idle();

        // Backpressure: 5-cycle stall near dibit 10.
        base = done_cnt;
        push_pkt();
        trigger();
        wait_dib(10);
        axior = 1'b0;
        step(5);
        axior = 1'b1;
        wait_done(base + 1);
        check("len_stall", 64'(last_len), 64'd37);
        check("count_after_2", 64'(pkt_count), 64'd2);
        wait_idle();

        // Merged triggers during SEND produce exactly one extra packet.
        do_reset();
        randomize_inputs();
        base = done_cnt;
        push_pkt();
        trigger();
        wait_dib(5);
        repeat (3) begin
            trigger();
            step(1);
        end
        push_pkt();
        wait_done(base + 2);
        step(120);
        check("merged_pkts", 64'(done_cnt - base), 64'd2);
        check("merged_queue_empty", 64'(exp_q.size()), 64'd0);
        check("merged_count", 64'(pkt_count), 64'd2);

        // Inputs change mid-packet.
        do_reset();
        randomize_inputs();
        old_x = player_x;
        base = done_cnt;
        push_pkt();
        trigger();
        wait_dib(4);
        player_x = ~old_x;
        wait_done(base + 1);
        wait_idle();
        push_pkt();
        trigger();
        wait_done(base + 2);
        wait_idle();

        // Reset mid-packet abandons it and clears counters.
        randomize_inputs();
        push_pkt();
        trigger();
        wait_dib(15);
        rst = 1'b1;
        step(1);
        check("rst_mid_axiov", 64'(axiov), 64'd0);
        check("rst_mid_count", 64'(pkt_count), 64'd0);
        exp_q.delete();
        model_seq = 8'd0;
        rst = 1'b0;
        step(1);
        randomize_inputs();
        base = done_cnt;
        push_pkt();
        trigger();
        wait_done(base + 1);
        check("rst_mid_count_after", 64'(pkt_count), 64'd1);
        wait_idle();

        // Wrap: 257 random packets with random backpressure.
        do_reset();
        rand_bp = 1;
        for (int i = 0; i < 257; i++) begin
            randomize_inputs();
            base = done_cnt;
            push_pkt();
            trigger();
            wait_done(base + 1);
            wait_idle();
            if (i == 255) check("wrap_count", 64'(pkt_count), 64'd0);
        end
        rand_bp = 0;
        check("wrap_count_257", 64'(pkt_count), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
